// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding controller: a shift-register scoreboard of in-flight
// destinations drives per-source operand selects, a pipeline stall and a stall counter.
module pipe_scoreboard #(
  parameter int unsigned RF_WIDTH   = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned LOAD_AVAIL = 1,
  parameter bit          ZERO_HARD  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fwdEn,
  input  logic                          idValid,
  input  logic                          idWriteEn,
  input  logic [RF_WIDTH-1:0]           idWriteAddr,
  input  logic                          idIsLoad,
  input  logic [NUM_SRC*RF_WIDTH-1:0]   idSrcAddr,
  input  logic [NUM_SRC-1:0]            idSrcUsed,
  input  logic                          clrCount,
  output logic                          stall,
  output logic [NUM_SRC*SEL_WIDTH-1:0]  selOp,
  output logic [CNT_WIDTH-1:0]          stallCount
);

  typedef struct packed {
    logic                v;
    logic                we;
    logic [RF_WIDTH-1:0] addr;
    logic                ld;
  } entry_t;

  entry_t                       sb [FWD_STAGES];
  logic [NUM_SRC-1:0]           src_stall;
  logic [NUM_SRC-1:0]           found;
  logic [SEL_WIDTH-1:0]         hit [NUM_SRC];
  logic [NUM_SRC*SEL_WIDTH-1:0] sel_raw;
  logic [RF_WIDTH-1:0]          src [NUM_SRC];

  // Ascending scan with a found flag keeps only the youngest (lowest-k) match.
  always_comb begin
    src_stall = '0;
    found     = '0;
    sel_raw   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      hit[i] = '0;
      src[i] = idSrcAddr[i*RF_WIDTH +: RF_WIDTH];
      for (int unsigned k = 0; k < FWD_STAGES; k++) begin
        if (!found[i] && idValid && idSrcUsed[i] &&
            sb[k].v && sb[k].we && (sb[k].addr == src[i]) &&
            !(ZERO_HARD && (src[i] == '0))) begin
          found[i] = 1'b1;
          hit[i]   = SEL_WIDTH'(k);
        end
      end
      if (found[i]) begin
        if (!fwdEn) begin
          src_stall[i] = 1'b1;
        end else if (sb[hit[i]].ld && (32'(hit[i]) < LOAD_AVAIL)) begin
          src_stall[i] = 1'b1;
        end else begin
          sel_raw[i*SEL_WIDTH +: SEL_WIDTH] = hit[i] + 1'b1;
        end
      end
    end
    stall = |src_stall;
    selOp = stall ? '0 : sel_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < FWD_STAGES; k++) sb[k] <= '0;
    end else begin
      for (int unsigned k = 1; k < FWD_STAGES; k++) sb[k] <= sb[k-1];
      if (idValid && !stall) sb[0] <= '{v: 1'b1, we: idWriteEn, addr: idWriteAddr, ld: idIsLoad};
      else                   sb[0] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
    end else if (clrCount) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule
